// File: rtl/map_table.sv
// Register alias table for the rename stage.
// Holds the speculative map, the retirement map and per-tag ready bits.
// Translates up to three sources pairs per cycle, with older in-bundle
// destinations forwarded to younger sources. Also returns the previous
// mapping (T_old) of each destination and installs the new tags.
// Slot 2 is the oldest slot and slot 0 the youngest.
// There is no handshake: lookups are purely combinational and the table
// accepts every update presented at the clock edge.
module map_table #(
  parameter int ARCH_REGS = 32,
  parameter int AR_W      = 5,
  parameter int PR_W      = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           rn_dispatch_en_mask,
  input  logic [2:0]           rn_dest_valid_mask,
  input  logic [3*AR_W-1:0]    rn_dest_arch,
  input  logic [3*AR_W-1:0]    rn_src1_arch,
  input  logic [3*AR_W-1:0]    rn_src2_arch,
  input  logic [3*PR_W-1:0]    fl_allocated_pr_list,
  input  logic [2:0]           cdb_valid_mask,
  input  logic [3*PR_W-1:0]    cdb_pr_list,
  input  logic [2:0]           rt_retire_en_mask,
  input  logic [3*AR_W-1:0]    rt_arch_list,
  input  logic [3*PR_W-1:0]    rt_pr_list,
  input  logic                 fch_rec_enable,
  output logic [3*PR_W-1:0]    rn_src1_pr,
  output logic [3*PR_W-1:0]    rn_src2_pr,
  output logic [2:0]           rn_src1_ready,
  output logic [2:0]           rn_src2_ready,
  output logic [3*PR_W-1:0]    rn_told_pr
);

  localparam int NUM_PR = 1 << PR_W;

  logic [PR_W-1:0]   map_q      [ARCH_REGS];
  logic [PR_W-1:0]   arch_map_q [ARCH_REGS];
  logic [NUM_PR-1:0] ready_q;

  logic [PR_W-1:0]   map_next   [ARCH_REGS];
  logic [PR_W-1:0]   arch_next  [ARCH_REGS];
  logic [NUM_PR-1:0] ready_next;

  // A slot installs a new mapping only when it dispatches and writes a dest.
  logic [2:0] wr_en;
  assign wr_en = rn_dispatch_en_mask & rn_dest_valid_mask;

  // True when any CDB lane completes the given tag this cycle.
  function automatic logic cdb_hit(input logic [PR_W-1:0] tag,
                                   input logic [2:0] vld,
                                   input logic [3*PR_W-1:0] lst);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (vld[j] && (lst[j*PR_W +: PR_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  for (genvar s = 0; s < 3; s++) begin : g_slot
    logic [AR_W-1:0] a1, a2, ad;
    logic [PR_W-1:0] t1, t2, td;
    logic            f1, f2;

    assign a1 = rn_src1_arch[s*AR_W +: AR_W];
    assign a2 = rn_src2_arch[s*AR_W +: AR_W];
    assign ad = rn_dest_arch[s*AR_W +: AR_W];

    // Base lookup from the map, overridden by the newest older in-bundle writer.
    always_comb begin
      t1 = map_q[a1];
      t2 = map_q[a2];
      td = map_q[ad];
      f1 = 1'b0;
      f2 = 1'b0;
      for (int k = 2; k > s; k--) begin
        if (wr_en[k] && (rn_dest_arch[k*AR_W +: AR_W] == a1)) begin
          t1 = fl_allocated_pr_list[k*PR_W +: PR_W];
          f1 = 1'b1;
        end
        if (wr_en[k] && (rn_dest_arch[k*AR_W +: AR_W] == a2)) begin
          t2 = fl_allocated_pr_list[k*PR_W +: PR_W];
          f2 = 1'b1;
        end
        if (wr_en[k] && (rn_dest_arch[k*AR_W +: AR_W] == ad)) begin
          td = fl_allocated_pr_list[k*PR_W +: PR_W];
        end
      end
    end

    assign rn_src1_pr[s*PR_W +: PR_W] = t1;
    assign rn_src2_pr[s*PR_W +: PR_W] = t2;
    // A forwarded tag was allocated this cycle, so it cannot be ready yet.
    assign rn_src1_ready[s] = !f1 && (ready_q[t1] || cdb_hit(t1, cdb_valid_mask, cdb_pr_list));
    assign rn_src2_ready[s] = !f2 && (ready_q[t2] || cdb_hit(t2, cdb_valid_mask, cdb_pr_list));
    assign rn_told_pr[s*PR_W +: PR_W] = wr_en[s] ? td : '0;
  end

  // Retirement map with this cycle's retires applied oldest first (slot 0 wins).
  always_comb begin
    arch_next = arch_map_q;
    for (int s = 2; s >= 0; s--) begin
      if (rt_retire_en_mask[s]) begin
        arch_next[rt_arch_list[s*AR_W +: AR_W]] = rt_pr_list[s*PR_W +: PR_W];
      end
    end
  end

  // Speculative map: restored on recovery, otherwise dispatch writes oldest first.
  always_comb begin
    map_next = map_q;
    if (fch_rec_enable) begin
      map_next = arch_next;
    end else begin
      for (int s = 2; s >= 0; s--) begin
        if (wr_en[s]) begin
          map_next[rn_dest_arch[s*AR_W +: AR_W]] = fl_allocated_pr_list[s*PR_W +: PR_W];
        end
      end
    end
  end

  // Ready bits: CDB completions set, new allocations clear and take priority.
  always_comb begin
    ready_next = ready_q;
    if (fch_rec_enable) begin
      ready_next = '1;
    end else begin
      for (int j = 0; j < 3; j++) begin
        if (cdb_valid_mask[j]) ready_next[cdb_pr_list[j*PR_W +: PR_W]] = 1'b1;
      end
      for (int s = 0; s < 3; s++) begin
        if (wr_en[s]) ready_next[fl_allocated_pr_list[s*PR_W +: PR_W]] = 1'b0;
      end
    end
  end

  // State registers; reset gives the identity map with every tag ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        map_q[i]      <= PR_W'(i);
        arch_map_q[i] <= PR_W'(i);
      end
      ready_q <= '1;
    end else begin
      map_q      <= map_next;
      arch_map_q <= arch_next;
      ready_q    <= ready_next;
    end
  end

endmodule
